// File: rtl/sweep_pkg.sv
// Shared types and constants for the sweep sequencer and its dwell timer.
package sweep_pkg;

  localparam int WIDTH_DEFAULT   = 8;
  localparam int DWELL_W_DEFAULT = 4;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    UP       = 3'd2,
    DWELL_HI = 3'd3,
    DOWN     = 3'd4,
    DWELL_LO = 3'd5
  } sweep_state_t;

endpackage

// File: rtl/sweep_ctrl_if.sv
// Control/feedback bundle between the sweep sequencer and the up/down counter stage.
interface sweep_ctrl_if #(
  parameter int WIDTH = 8
);
  // Counter contract: load beats enable; with enable, dir=0 counts up and
  // dir=1 counts down; count_in is the counter register, updated on the same
  // clk edge that samples load/enable.
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             enable;
  logic             dir;
  logic [WIDTH-1:0] count_in;

  modport master (
    output load,
    output load_data,
    output enable,
    output dir,
    input  count_in
  );

  modport slave (
    input  load,
    input  load_data,
    input  enable,
    input  dir,
    output count_in
  );
endinterface

// File: rtl/dwell_timer.sv
// Loadable down-counter; expire is high during the last cycle of a loaded hold.
module dwell_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // A hold of N cycles sees cnt = N, N-1, ..., 1; the turnaround fires on 1.
  assign expire = (cnt == W'(1));

endmodule

// File: rtl/sweep_ctrl.sv
// Triangle-sweep sequencer for the up/down counter stage.
// Dwell holds at the turnarounds are built only when SWEEP_CTRL_DWELL_EN is defined.
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int DWELL_W = DWELL_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [WIDTH-1:0]   lo_limit,
  input  logic [WIDTH-1:0]   hi_limit,
  input  logic [7:0]         num_sweeps,
  input  logic [DWELL_W-1:0] dwell_cycles,
  sweep_ctrl_if.master       ctr,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [7:0]         sweep_cnt,
  output sweep_state_t       state_dbg
);

  sweep_state_t     state, state_nxt;
  logic [WIDTH-1:0] lo_c, hi_c;
  logic [7:0]       num_c;
  logic [7:0]       sweep_inc;
  logic             at_hi, at_lo, start_ok, start_bad, finish;

`ifdef SWEEP_CTRL_DWELL_EN
  logic [DWELL_W-1:0] dwell_c;
  logic               dwell_go, timer_load, timer_exp;

  assign dwell_go = (dwell_c != '0);

  dwell_timer #(.W(DWELL_W)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (dwell_c),
    .expire   (timer_exp)
  );
`else
  logic unused_dwell;
  assign unused_dwell = ^dwell_cycles;
`endif

  assign at_hi     = (ctr.count_in == hi_c);
  assign at_lo     = (ctr.count_in == lo_c);
  assign start_ok  = start & ~stop & (lo_limit < hi_limit);
  assign start_bad = start & ~stop & ~(lo_limit < hi_limit);
  assign sweep_inc = sweep_cnt + 8'd1;
  assign finish    = (num_c != 8'd0) && (sweep_inc == num_c);

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
`ifdef SWEEP_CTRL_DWELL_EN
    timer_load = 1'b0;
`endif
    case (state)
      IDLE: if (start_ok) state_nxt = LOAD;
      LOAD: state_nxt = UP;
      UP: begin
        if (at_hi) begin
`ifdef SWEEP_CTRL_DWELL_EN
          if (dwell_go) begin
            state_nxt  = DWELL_HI;
            timer_load = 1'b1;
          end else
`endif
          state_nxt = DOWN;
        end
      end
      DOWN: begin
        if (at_lo) begin
          if (finish) begin
            state_nxt = IDLE;
          end else begin
`ifdef SWEEP_CTRL_DWELL_EN
            if (dwell_go) begin
              state_nxt  = DWELL_LO;
              timer_load = 1'b1;
            end else
`endif
            state_nxt = UP;
          end
        end
      end
`ifdef SWEEP_CTRL_DWELL_EN
      DWELL_HI: if (timer_exp) state_nxt = DOWN;
      DWELL_LO: if (timer_exp) state_nxt = UP;
`endif
      default: state_nxt = IDLE;
    endcase
    // Abort overrides every transition out of a running state.
    if (stop && (state != IDLE)) state_nxt = IDLE;
  end

  always_comb begin
    ctr.load      = (state == LOAD);
    ctr.load_data = (state == LOAD) ? lo_c : '0;
    ctr.dir       = ((state == DOWN) || (state == DWELL_LO)) ? DIR_DOWN : DIR_UP;
    ctr.enable    = 1'b0;
    if (state == UP)   ctr.enable = ~at_hi & ~stop;
    if (state == DOWN) ctr.enable = ~at_lo & ~stop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_c      <= '0;
      hi_c      <= '0;
      num_c     <= '0;
      sweep_cnt <= '0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
`ifdef SWEEP_CTRL_DWELL_EN
      dwell_c   <= '0;
`endif
    end else begin
      done    <= (state == DOWN) & at_lo & finish & ~stop;
      cfg_err <= (state == IDLE) & start_bad;
      if ((state == IDLE) && start_ok) begin
        lo_c      <= lo_limit;
        hi_c      <= hi_limit;
        num_c     <= num_sweeps;
        sweep_cnt <= '0;
`ifdef SWEEP_CTRL_DWELL_EN
        dwell_c   <= dwell_cycles;
`endif
      end else if ((state == DOWN) && at_lo && !stop) begin
        sweep_cnt <= sweep_inc;
      end
    end
  end

endmodule
